// File: rtl/leb128_window_feed_pkg.sv
// Shared LEB128 definitions used by the window feeder and the unpackers.
// Optional feature macro used by the feeder: LEB128_OVERLONG_CHECK_EN.
package leb128_pkg;

    localparam int LEB128_MAX_BYTES = 10;
    localparam int LEB128_CONT_BIT  = 7;

    // Element 0 occupies bits [7:0] and is the oldest byte of the value.
    typedef logic [LEB128_MAX_BYTES-1:0][7:0] leb128_window_t;
    typedef logic [LEB128_MAX_BYTES-1:0]      leb128_mask_t;

endpackage

// File: rtl/leb128_window_feed_if.sv
// Byte-stream input and window output handshake bundle for leb128_window_feed.
// Optional feature macro affecting w_err: LEB128_OVERLONG_CHECK_EN.
interface leb128_window_feed_if;
    import leb128_pkg::*;

    logic [7:0]                    s_data;
    logic                          s_valid;
    logic                          s_ready;
    logic [8*LEB128_MAX_BYTES-1:0] w_bytes;
    logic [3:0]                    w_len;
    logic                          w_valid;
    logic                          w_ready;
    logic                          w_err;

    // Producer of bytes / consumer of windows.
    modport master (
        output s_data, s_valid, w_ready,
        input  s_ready, w_bytes, w_len, w_valid, w_err
    );

    // The feeder itself.
    modport slave (
        input  s_data, s_valid, w_ready,
        output s_ready, w_bytes, w_len, w_valid, w_err
    );

endinterface

// File: rtl/leb128_window_feed_term_find.sv
// Combinational search for the first LEB128 terminator byte (bit7 clear)
// among the valid slots of a window; len is the value length in bytes.
module leb128_term_find
    import leb128_pkg::*;
(
    input  leb128_window_t win,
    input  leb128_mask_t   mask,
    output logic           found,
    output logic [3:0]     len
);

    // Scan from the top slot down so the lowest matching slot wins.
    always_comb begin
        logic [3:0] idx;
        found = 1'b0;
        len   = '0;
        idx   = '0;
        for (int unsigned k = LEB128_MAX_BYTES; k > 0; k--) begin
            idx = 4'(k - 1);
            if (mask[idx] && !win[idx][LEB128_CONT_BIT]) begin
                found = 1'b1;
                len   = 4'(k);
            end
        end
    end

endmodule

// File: rtl/leb128_window_feed.sv
// Byte buffer feeding LEB128 unpackers: presents a 10-byte window aligned to
// the next encoded value once its whole encoding is buffered, and drops
// exactly that value's bytes on the consumer handshake.
// Optional feature macro: LEB128_OVERLONG_CHECK_EN (flags overlong windows on w_err).
module leb128_window_feed
    import leb128_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    leb128_window_feed_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     mem_d [DEPTH];
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [CW-1:0]  pop_n;
    logic [CW-1:0]  wr_idx;
    leb128_window_t win;
    leb128_mask_t   mask;
    logic           found;
    logic           full_win;
    logic           push;
    logic           pop;
    logic [3:0]     t_len;
    logic [3:0]     len;

    // Window slots beyond the buffered count read as zero and are masked out.
    always_comb begin
        win  = '0;
        mask = '0;
        for (int unsigned k = 0; k < LEB128_MAX_BYTES; k++) begin
            if (k < 32'(count_q)) begin
                mask[4'(k)] = 1'b1;
                win[4'(k)]  = mem_q[IW'(k)];
            end
        end
    end

    leb128_term_find u_term_find (
        .win   (win),
        .mask  (mask),
        .found (found),
        .len   (t_len)
    );

    assign full_win = (count_q >= CW'(LEB128_MAX_BYTES));
    assign len      = found ? t_len : (full_win ? 4'(LEB128_MAX_BYTES) : 4'd0);

    assign bus.w_valid = found | full_win;
    assign bus.w_len   = len;
    assign bus.w_bytes = win;
    assign bus.s_ready = (count_q < CW'(DEPTH));

`ifdef LEB128_OVERLONG_CHECK_EN
    assign bus.w_err = full_win & ~found;
`else
    assign bus.w_err = 1'b0;
`endif

    assign pop    = bus.w_valid & bus.w_ready;
    assign push   = bus.s_valid & bus.s_ready;
    assign pop_n  = pop ? CW'(len) : '0;
    assign wr_idx = count_q - pop_n;

    // Shift out the popped value, then append the new byte behind what remains.
    always_comb begin
        int unsigned src;
        mem_d = '{default: '0};
        src   = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            src = i + 32'(pop_n);
            if (src < 32'(DEPTH)) begin
                mem_d[IW'(i)] = mem_q[IW'(src)];
            end
        end
        if (push) begin
            mem_d[IW'(wr_idx)] = bus.s_data;
        end
        count_d = count_q - pop_n + CW'(push);
    end

    // Buffer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_leb128_window_feed.sv
// Directed bench for leb128_window_feed: a vector table for single-value
// scenarios plus hand-written full-buffer and streaming/reset sequences.
// Honours LEB128_OVERLONG_CHECK_EN for the expected w_err of overlong windows.
module tb_leb128_window_feed;
    import leb128_pkg::*;

`ifdef LEB128_OVERLONG_CHECK_EN
    localparam logic OVL_ERR = 1'b1;
`else
    localparam logic OVL_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    leb128_window_feed_if bus ();

    leb128_window_feed #(.DEPTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        sv;
        logic [7:0]  sd;
        logic        wr;
        logic        ev;
        logic [3:0]  elen;
        logic        eerr;
        logic [79:0] ebytes;
        logic        dchk;
        longint      dexp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic [7:0] sd, input logic wr,
                       input logic ev, input logic [3:0] elen, input logic eerr,
                       input logic [79:0] eb, input logic dchk = 1'b0,
                       input longint dexp = 0);
        vec_t v;
        v.sv = sv; v.sd = sd; v.wr = wr; v.ev = ev; v.elen = elen;
        v.eerr = eerr; v.ebytes = eb; v.dchk = dchk; v.dexp = dexp;
        vecs.push_back(v);
    endtask

    function automatic logic [79:0] lo_bytes(input logic [79:0] b, input int n);
        logic [79:0] r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = b[8*k +: 8];
        return r;
    endfunction

    // Reference signed LEB128 decode of the first n window bytes.
    function automatic longint dec_s64(input logic [79:0] b, input int n);
        longint     r  = 0;
        int         sh = 0;
        logic [7:0] by = '0;
        for (int k = 0; k < n; k++) begin
            by = b[8*k +: 8];
            if (sh < 64) r |= longint'(by[6:0]) << sh;
            sh += 7;
        end
        if (sh < 64 && by[6]) r |= -(longint'(1) << sh);
        return r;
    endfunction

    initial begin
        reset_n     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.w_ready = 1'b0;
        #2;
        chk("rst_w_valid", bus.w_valid, 0);
        chk("rst_w_len", bus.w_len, 0);
        chk("rst_w_bytes", bus.w_bytes, 0);
        chk("rst_w_err", bus.w_err, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single-byte value and handshake.
        add(1, 8'h01, 0, 0, 0, 0, 80'h0);
        add(0, 8'h00, 1, 1, 1, 0, 80'h01);
        add(0, 8'h00, 0, 0, 0, 0, 80'h0);
        // 80 80 80 80 0c followed by bc 0b.
        repeat (4) add(1, 8'h80, 0, 0, 0, 0, 80'h0);
        add(1, 8'h0c, 0, 0, 0, 0, 80'h0);
        add(1, 8'hbc, 0, 1, 5, 0, 80'h0c80808080);
        add(1, 8'h0b, 1, 1, 5, 0, 80'h0c80808080);
        add(0, 8'h00, 0, 1, 2, 0, 80'h0bbc);
        add(0, 8'h00, 1, 1, 2, 0, 80'h0bbc);
        add(0, 8'h00, 0, 0, 0, 0, 80'h0);
        // Nine ff then 01: a full 10-byte terminated value, decodes to -1.
        repeat (9) add(1, 8'hff, 0, 0, 0, 0, 80'h0);
        add(1, 8'h01, 0, 0, 0, 0, 80'h0);
        add(0, 8'h00, 1, 1, 10, 0, 80'h01ffffffffffffffffff, 1'b1, -1);
        add(0, 8'h00, 0, 0, 0, 0, 80'h0);
        // Ten 80: overlong window.
        repeat (10) add(1, 8'h80, 0, 0, 0, 0, 80'h0);
        add(0, 8'h00, 1, 1, 10, OVL_ERR, 80'h80808080808080808080);
        add(0, 8'h00, 0, 0, 0, 0, 80'h0);

        foreach (vecs[i]) begin
            bus.s_valid = vecs[i].sv;
            bus.s_data  = vecs[i].sd;
            bus.w_ready = vecs[i].wr;
            @(negedge clk);
            chk($sformatf("v%0d_w_valid", i), bus.w_valid, vecs[i].ev);
            chk($sformatf("v%0d_w_len", i), bus.w_len, vecs[i].elen);
            chk($sformatf("v%0d_w_err", i), bus.w_err, vecs[i].eerr);
            chk($sformatf("v%0d_s_ready", i), bus.s_ready, 1);
            if (vecs[i].ev)
                chk($sformatf("v%0d_w_bytes", i), lo_bytes(bus.w_bytes, int'(vecs[i].elen)), vecs[i].ebytes);
            if (vecs[i].dchk)
                chk($sformatf("v%0d_decode", i), 80'(dec_s64(bus.w_bytes, int'(bus.w_len))), 80'(vecs[i].dexp));
            @(posedge clk);
            #1;
        end

        // Fill the buffer with sixteen 01 while the consumer stalls.
        bus.w_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h01;
        repeat (16) @(posedge clk);
        #1;
        bus.s_data  = 8'h02;
        bus.w_ready = 1'b1;
        @(negedge clk);
        chk("full_s_ready", bus.s_ready, 0);
        chk("full_w_valid", bus.w_valid, 1);
        chk("full_w_len", bus.w_len, 1);
        @(posedge clk);
        #1;
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_s_ready", bus.s_ready, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("refull_s_ready", bus.s_ready, 0);
        @(posedge clk);
        #1;
        bus.w_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_w_valid", i), bus.w_valid, 1);
            chk($sformatf("drain%0d_w_len", i), bus.w_len, 1);
            chk($sformatf("drain%0d_byte", i), bus.w_bytes[7:0], (i < 15) ? 8'h01 : 8'h02);
            @(posedge clk);
            #1;
        end
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("drained_w_valid", bus.w_valid, 0);
        @(posedge clk);
        #1;

        // Back-to-back 1-byte values with concurrent push and pop.
        bus.w_ready = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.s_data = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 0) begin
                chk("stream0_w_valid", bus.w_valid, 0);
            end else begin
                chk($sformatf("stream%0d_w_valid", i), bus.w_valid, 1);
                chk($sformatf("stream%0d_byte", i), bus.w_bytes[7:0], 8'(8'h10 + i - 1));
            end
            @(posedge clk);
            #1;
        end

        // Reset mid-stream while a value is buffered.
        bus.s_data = 8'h77;
        reset_n    = 1'b0;
        #1;
        chk("midrst_w_valid", bus.w_valid, 0);
        chk("midrst_w_len", bus.w_len, 0);
        chk("midrst_w_bytes", bus.w_bytes, 0);
        chk("midrst_s_ready", bus.s_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n     = 1'b1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("postrst_w_valid", bus.w_valid, 0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h05;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("restart_w_valid", bus.w_valid, 1);
        chk("restart_w_len", bus.w_len, 1);
        chk("restart_byte", bus.w_bytes[7:0], 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
